// File: rtl/seq_mul_et.sv
// Sequential shift-and-add multiplier (unsigned/signed) with early termination and a step-count output.
// Latency: 1 edge when either operand is zero, else msb_index(|b|)+2 edges from accept to out_valid.
// Backpressure: o/out_valid held in DONE until out_ready; in_ready only in IDLE and never during in_rst.
// Optional macro SEQ_MUL_CONST_TIME_EN: fixed WIDTH steps (L = WIDTH+1) for every operand pair.
module seq_mul_et #(
  parameter int WIDTH     = 32,
  parameter int OUT_WIDTH = 2 * WIDTH,
  parameter int CNT_WIDTH = $clog2(WIDTH) + 1
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [OUT_WIDTH-1:0] o,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] steps
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       a_q, a_d;
  logic [WIDTH-1:0]       b_q, b_d;
  logic [OUT_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   neg_q, neg_d;
  logic [OUT_WIDTH-1:0]   o_q, o_d;
  logic [CNT_WIDTH-1:0]   steps_q, steps_d;

  logic                   term;
  logic [OUT_WIDTH-1:0]   addend;
  logic [OUT_WIDTH-1:0]   result;

  // Magnitude of a WIDTH-bit two's-complement value; -2^(WIDTH-1) maps to 2^(WIDTH-1) unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    mag = (sgn && x[WIDTH-1]) ? ({WIDTH{1'b0}} - x) : x;
  endfunction

  assign in_ready  = (state_q == S_IDLE) && !in_rst;
  assign out_valid = (state_q == S_DONE);
  assign o         = o_q;
  assign steps     = steps_q;

`ifdef SEQ_MUL_CONST_TIME_EN
  // Fixed step count so that timing does not depend on the operand values.
  assign term = (cnt_q == CNT_WIDTH'(WIDTH));
`else
  // Stop as soon as no further partial product can be non-zero.
  assign term = (a_q == '0) || (b_q == '0);
`endif

  assign addend = b_q[0] ? ({{(OUT_WIDTH-WIDTH){1'b0}}, a_q} << cnt_q) : '0;
  assign result = neg_q ? ({OUT_WIDTH{1'b0}} - acc_q) : acc_q;

  // Next-state and datapath update; every target defaults to holding its value.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    o_d     = o_q;
    steps_d = steps_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          state_d = S_BUSY;
          a_d     = mag(a, in_signed);
          b_d     = mag(b, in_signed);
          neg_d   = in_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      S_BUSY: begin
        if (term) begin
          state_d = S_DONE;
          o_d     = result;
          steps_d = cnt_q;
        end else begin
          acc_d = acc_q + addend;
          b_d   = b_q >> 1;
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset that aborts any operation.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      o_q     <= '0;
      steps_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      o_q     <= o_d;
      steps_q <= steps_d;
    end
  end

endmodule
